fpu_ss_prd_arbiter: RTL and testbench
=====================================

// Module: fpu_ss_prd_arbiter
// PURPOSE
// Shares one FPU-subsystem predecoder among NumReq offload requesters (harts or issue ports).
// Grants one predecode request at a time, round-robin, and drives the registered instruction to the predecoder.
// Captures the predecoder response and returns it to the granted requester with a valid/ready handshake.
// Sits between the core-side offload interfaces and the combinational predecoder.
// PARAMETERS
// NumReq      2   number of requesters, >=2
// IdxWidth    $clog2(NumReq)  derived, width of the grant index and the RR pointer; do not override
// PORTS
// clk_i             in   1              clock
// rst_i             in   1              asynchronous active-high reset
// req_valid_i       in   NumReq         requester i has a predecode request
// req_ready_o       out  NumReq         request of requester i accepted this cycle (one-hot or zero)
// req_instr_i       in   NumReq*32      instruction word of requester i, slice [32*i+:32]
// rsp_valid_o       out  NumReq         response valid for requester i (one-hot or zero)
// rsp_ready_i       in   NumReq         requester i takes the response
// rsp_o             out  acc_prd_rsp_t  shared response bus: p_accept, p_writeback, p_is_mem_op, p_use_rs[2:0]
// prd_req_o         out  acc_prd_req_t  to predecoder; q_instr_data = latched instruction
// prd_rsp_i         in   acc_prd_rsp_t  from predecoder, combinational on prd_req_o
// flush_i           in   1              abort the in-flight transaction
// busy_o            out  1              state != IDLE
// BEHAVIOUR
// - Reset (async, rst_i=1): state IDLE, rr_ptr=0, instr_q=0, owner_q=0, rsp_q=0. req_ready_o=0, rsp_valid_o=0,
//   rsp_o=0, prd_req_o=0, busy_o=0. Reset mid-transaction drops it silently; no response is ever issued for it.
// - FSM fpu_ss_prd_arb_state_e {IDLE, LOOKUP, RESP}.
// - IDLE: if any req_valid_i, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NumReq.
//   Assert req_ready_o[winner] combinationally in the same cycle. Latch instr_q<=req_instr_i[winner] and owner_q<=winner.
//   Set rr_ptr<=(winner+1) mod NumReq; winner NumReq-1 wraps to 0. Go to LOOKUP.
//   If no request, stay in IDLE.
// - LOOKUP: prd_req_o.q_instr_data=instr_q. Latch rsp_q<=prd_rsp_i at the clock edge, then go to RESP.
// - RESP: rsp_valid_o[owner_q]=1 and rsp_o=rsp_q. Both stay stable until rsp_ready_i[owner_q]=1.
//   On that handshake go to IDLE. rsp_ready_i of non-owners is ignored.
// - Latency: request handshake at cycle N gives rsp_valid_o at cycle N+2. Earliest next grant is at the cycle after the response handshake.
//   Peak throughput is 1 request per 3 cycles.
// - req_ready_o is 0 in LOOKUP and RESP. rsp_valid_o is 0 outside RESP.
//   prd_req_o is 0 in IDLE, and is instr_q in LOOKUP and RESP.
// - flush_i=1 in LOOKUP or RESP: next state IDLE, rsp_valid_o deasserts next cycle, and no handshake is required.
//   rr_ptr keeps its advanced value. flush_i in IDLE has priority over a grant: req_ready_o=0 and the state is unchanged.
// - flush_i together with a response handshake in RESP: the transfer counts as completed. Next state IDLE; no retry.
// - Unknown instruction: the predecoder returns all-zero, and it is still returned with p_accept=0. The arbiter never filters.
// - req_valid_i may drop without a handshake. Arbitration is re-evaluated every IDLE cycle, with no lock.
// - Fairness: a continuously requesting requester is granted within NumReq grants.
// STRUCTURE
// - fpu_ss_pkg: add typedef enum logic [1:0] fpu_ss_prd_arb_state_e {IDLE=0, LOOKUP=1, RESP=2}.
//   Reuse the existing acc_prd_req_t and acc_prd_rsp_t. No new constants.
// - Sub-module fpu_ss_rr_pick #(NumReq): combinational; inputs req vector and rr_ptr, outputs valid, idx, and one-hot grant.
// - The predecoder is external; this block does not instantiate it. It contains only the FSM, the rr_ptr/owner/instr/rsp registers, and output muxing.
// TESTING
// - Req0 only, instr FADD_S: req_ready_o=01 at cycle 0, rsp_valid_o=01 at cycle 2, rsp_o={accept=1, wb=0, mem=0, use_rs=000}, rr_ptr=1.
// - After reset, req_valid_i=11 with FLW on req0 and FMV_X_W on req1: grant req0 (rsp {1,0,1,001}), then req1 (rsp {1,1,0,000}).
//   Third grant goes back to req0 (wrap).
// - Backpressure: hold rsp_ready_i=00 for 5 cycles in RESP. rsp_valid_o and rsp_o stay stable and req_ready_o=00.
//   rsp_ready_i=10 (non-owner) has no effect.
// - Instr 32'h0000_0000: rsp_valid_o is asserted with rsp_o all-zero (accept=0).
// - flush_i pulse in LOOKUP: rsp_valid_o is never asserted, busy_o=0 next cycle, and the next grant follows the advanced rr_ptr.
// - rst_i asserted in RESP, between clock edges: all outputs are 0 immediately.
//   After release with req_valid_i=10, req1 is granted (rr_ptr=0 scan).

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// ============================================================================
// Module : fpu_ss_pkg
// Brief  : Shared types for the FPU subsystem predecoder path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fpu_ss_pkg;

    typedef struct packed {
        logic [31:0] q_instr_data;
    } acc_prd_req_t;

    typedef struct packed {
        logic       p_accept;
        logic       p_writeback;
        logic       p_is_mem_op;
        logic [2:0] p_use_rs;
    } acc_prd_rsp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } fpu_ss_prd_arb_state_e;

endpackage

`default_nettype wire

// File: rtl/fpu_ss_rr_pick.sv
// ============================================================================
// Module : fpu_ss_rr_pick
// Brief  : Combinational round-robin picker; first set request at or after rr_ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fpu_ss_rr_pick #(
    parameter int NumReq   = 2,
    parameter int IdxWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] rr_ptr,
    output logic                valid,
    output logic [IdxWidth-1:0] idx,
    output logic [NumReq-1:0]   grant
);

    int unsigned w_cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = 0;
        // Scan rr_ptr, rr_ptr+1, ... wrapping at NumReq; keep the first hit.
        for (int i = 0; i < NumReq; i++) begin
            w_cand = 32'(rr_ptr) + 32'(i);
            if (w_cand >= 32'(NumReq)) begin
                w_cand = w_cand - 32'(NumReq);
            end
            if (!valid && req[w_cand[IdxWidth-1:0]]) begin
                valid = 1'b1;
                idx   = w_cand[IdxWidth-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_ss_prd_arbiter.sv
// ============================================================================
// Module : fpu_ss_prd_arbiter
// Brief  : Round-robin sharing of one predecoder among NumReq offload requesters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fpu_ss_prd_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int NumReq   = 2,
    parameter int IdxWidth = $clog2(NumReq)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumReq-1:0]    req_valid_i,
    output logic [NumReq-1:0]    req_ready_o,
    input  logic [NumReq*32-1:0] req_instr_i,
    output logic [NumReq-1:0]    rsp_valid_o,
    input  logic [NumReq-1:0]    rsp_ready_i,
    output acc_prd_rsp_t         rsp_o,
    output acc_prd_req_t         prd_req_o,
    input  acc_prd_rsp_t         prd_rsp_i,
    input  logic                 flush_i,
    output logic                 busy_o
);

    fpu_ss_prd_arb_state_e r_state;
    fpu_ss_prd_arb_state_e w_state_next;

    logic [IdxWidth-1:0] r_rr_ptr;
    logic [IdxWidth-1:0] r_owner;
    logic [31:0]         r_instr;
    acc_prd_rsp_t        r_rsp;

    logic                w_pick_valid;
    logic [IdxWidth-1:0] w_pick_idx;
    logic [NumReq-1:0]   w_pick_grant;
    logic                w_grant_fire;
    logic                w_rsp_capture;

    fpu_ss_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .req    (req_valid_i),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx),
        .grant  (w_pick_grant)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_fire  = 1'b0;
        w_rsp_capture = 1'b0;
        req_ready_o   = '0;
        rsp_valid_o   = '0;
        rsp_o         = '0;
        prd_req_o     = '0;
        busy_o        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                // A flush in IDLE suppresses the grant for this cycle.
                if (!flush_i && w_pick_valid) begin
                    w_grant_fire = 1'b1;
                    req_ready_o  = w_pick_grant;
                    w_state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                prd_req_o.q_instr_data = r_instr;
                if (flush_i) begin
                    w_state_next = IDLE;
                end else begin
                    w_rsp_capture = 1'b1;
                    w_state_next  = RESP;
                end
            end
            RESP: begin
                prd_req_o.q_instr_data = r_instr;
                rsp_valid_o[r_owner]   = 1'b1;
                rsp_o                  = r_rsp;
                if (flush_i || rsp_ready_i[r_owner]) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_instr  <= '0;
            r_rsp    <= '0;
        end else begin
            if (w_grant_fire) begin
                r_owner  <= w_pick_idx;
                r_instr  <= req_instr_i[{w_pick_idx, 5'b00000} +: 32];
                r_rr_ptr <= (w_pick_idx == IdxWidth'(NumReq - 1)) ? '0
                                                                  : w_pick_idx + IdxWidth'(1);
            end
            if (w_rsp_capture) begin
                r_rsp <= prd_rsp_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_ss_prd_arbiter.sv
// ============================================================================
// Module : tb_fpu_ss_prd_arbiter
// Brief  : Directed bench with a transaction-level reference model of the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_ss_prd_arbiter;
    import fpu_ss_pkg::*;

    localparam int N = 2;
    localparam logic [31:0] FADD_S  = 32'h0020_8053;
    localparam logic [31:0] FLW     = 32'h0000_2007;
    localparam logic [31:0] FMV_X_W = 32'hE000_0053;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_instr = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    acc_prd_rsp_t    rsp;
    acc_prd_req_t    prd_req;
    acc_prd_rsp_t    prd_rsp;
    logic            flush = 1'b0;
    logic            busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_ss_prd_arbiter #(.NumReq(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_instr_i (req_instr),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_o       (rsp),
        .prd_req_o   (prd_req),
        .prd_rsp_i   (prd_rsp),
        .flush_i     (flush),
        .busy_o      (busy)
    );

    // Stand-in predecoder: {accept, writeback, is_mem_op, use_rs[2:0]}.
    function automatic logic [5:0] predecode(input logic [31:0] instr);
        case (instr)
            FADD_S:  return 6'b100_000;
            FLW:     return 6'b101_001;
            FMV_X_W: return 6'b110_000;
            default: return 6'b000_000;
        endcase
    endfunction

    assign prd_rsp = predecode(prd_req.q_instr_data);

    function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Reference model: one transaction at a time, aged in cycles since grant.
    logic        m_active;
    int          m_age;
    int          m_owner;
    int          m_ptr;
    logic [31:0] m_instr;
    logic [5:0]  m_rsp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_owner  <= 0;
            m_ptr    <= 0;
            m_instr  <= '0;
            m_rsp    <= '0;
        end else if (!m_active) begin
            if (!flush && rr_winner(req_valid, m_ptr) >= 0) begin
                m_active <= 1'b1;
                m_age    <= 0;
                m_owner  <= rr_winner(req_valid, m_ptr);
                m_instr  <= req_instr[32*rr_winner(req_valid, m_ptr) +: 32];
                m_ptr    <= (rr_winner(req_valid, m_ptr) + 1) % N;
            end
        end else if (m_age == 0) begin
            if (flush) begin
                m_active <= 1'b0;
            end else begin
                m_age <= 1;
                m_rsp <= predecode(m_instr);
            end
        end else if (flush || rsp_ready[m_owner]) begin
            m_active <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic [N-1:0] e_valid;
        e_ready = '0;
        e_valid = '0;
        if (!m_active && !flush && rr_winner(req_valid, m_ptr) >= 0)
            e_ready[rr_winner(req_valid, m_ptr)] = 1'b1;
        if (m_active && m_age >= 1)
            e_valid[m_owner] = 1'b1;
        chk("model_req_ready", 32'(req_ready), 32'(e_ready));
        chk("model_rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("model_rsp", 32'(rsp), (m_active && m_age >= 1) ? 32'(m_rsp) : 32'd0);
        chk("model_prd_req", prd_req.q_instr_data, m_active ? m_instr : 32'd0);
        chk("model_busy", 32'(busy), 32'(m_active));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) step();
        rsp_ready = '0;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        flush     = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        at_neg();
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;

        // Single FADD.S from requester 0.
        step(); req_valid = 2'b01; req_instr[31:0] = FADD_S;
        at_neg(); chk("fadd_grant", 32'(req_ready), 32'h1);
        step(); req_valid = 2'b00;
        at_neg(); chk("fadd_lookup_valid", 32'(rsp_valid), 32'h0);
        step(); rsp_ready = 2'b01;
        at_neg(); chk("fadd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("fadd_rsp", 32'(rsp), 32'b100_000);
        step(); rsp_ready = 2'b00; req_valid = 2'b11;
        at_neg(); chk("ptr_after_fadd", 32'(req_ready), 32'h2);
        do_reset();

        // Both requesting after reset: 0, then 1, then wrap to 0.
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_instr = {FMV_X_W, FLW};
        at_neg(); chk("rr_first", 32'(req_ready), 32'h1);
        step(); step();
        at_neg(); chk("flw_rsp", 32'(rsp), 32'b101_001);
        step();
        at_neg(); chk("rr_second", 32'(req_ready), 32'h2);
        step(); step();
        at_neg(); chk("fmv_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("fmv_rsp", 32'(rsp), 32'b110_000);
        step();
        at_neg(); chk("rr_wrap", 32'(req_ready), 32'h1);
        drain();

        // Backpressure with non-owner ready.
        step(); req_valid = 2'b01; req_instr[31:0] = FADD_S;
        at_neg(); chk("bp_grant", 32'(req_ready), 32'h1);
        step(); req_valid = 2'b11; req_instr[63:32] = FMV_X_W;
        for (int k = 0; k < 5; k++) begin
            step(); rsp_ready = (k < 3) ? 2'b00 : 2'b10;
            at_neg();
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp", 32'(rsp), 32'b100_000);
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        step(); rsp_ready = 2'b01;
        step(); rsp_ready = 2'b00;
        at_neg(); chk("bp_next_grant", 32'(req_ready), 32'h2);
        drain();

        // Unknown (all-zero) instruction still answered.
        step(); req_valid = 2'b01; req_instr[31:0] = 32'h0;
        at_neg(); chk("zero_grant", 32'(req_ready), 32'h1);
        step(); req_valid = 2'b00;
        step(); rsp_ready = 2'b01;
        at_neg(); chk("zero_valid", 32'(rsp_valid), 32'h1);
        chk("zero_rsp", 32'(rsp), 32'h0);
        step(); rsp_ready = 2'b00;

        // Flush in IDLE, in LOOKUP, and together with a handshake in RESP.
        step(); req_valid = 2'b11; req_instr = {FMV_X_W, FADD_S}; flush = 1'b1;
        at_neg(); chk("flush_idle_ready", 32'(req_ready), 32'h0);
        step(); flush = 1'b0;
        at_neg(); chk("flush_idle_grant", 32'(req_ready), 32'h2);
        step(); flush = 1'b1;
        at_neg(); chk("flush_lookup_valid", 32'(rsp_valid), 32'h0);
        step(); flush = 1'b0;
        at_neg(); chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_regrant", 32'(req_ready), 32'h1);
        step(); req_valid = 2'b00;
        step(); flush = 1'b1; rsp_ready = 2'b01;
        at_neg(); chk("flush_hs_valid", 32'(rsp_valid), 32'h1);
        step(); flush = 1'b0; rsp_ready = 2'b00;
        at_neg(); chk("flush_hs_idle", 32'(busy), 32'h0);

        // Asynchronous reset while in RESP.
        step(); req_valid = 2'b10;
        at_neg(); chk("rst_pre_grant", 32'(req_ready), 32'h2);
        step(); req_valid = 2'b00;
        step();
        at_neg(); chk("rst_pre_valid", 32'(rsp_valid), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(rsp_valid), 32'h0);
        chk("rst_async_rsp", 32'(rsp), 32'h0);
        chk("rst_async_prd", prd_req.q_instr_data, 32'h0);
        chk("rst_async_busy", 32'(busy), 32'h0);
        step(); rst = 1'b0; req_valid = 2'b10;
        at_neg(); chk("rst_post_grant", 32'(req_ready), 32'h2);
        drain();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
